// File: rtl/branch_pred_ctrl_if.sv
// branch_pred_ctrl_if: fetch, execute and branch-history-table signals of the predictor controller.
interface branch_pred_ctrl_if #(parameter int LOWER = 5);
  logic             fetch_valid;
  logic [LOWER-1:0] fetch_idx;
  logic             fetch_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             resolve_jump;
  logic             flush;
  logic             bht_rd_en;
  logic [LOWER-1:0] bht_rd_idx;
  logic             bht_pred;
  logic             bht_upd_en;
  logic [LOWER-1:0] bht_upd_idx;
  logic             bht_upd_taken;
  logic [15:0]      mispredict_cnt;
  logic             resolve_err;
  modport master (
    output fetch_valid, fetch_idx, resolve_valid, resolve_taken, resolve_jump, bht_pred,
    input  fetch_ready, pred_valid, pred_taken, flush, bht_rd_en, bht_rd_idx,
           bht_upd_en, bht_upd_idx, bht_upd_taken, mispredict_cnt, resolve_err
  );
  modport slave (
    input  fetch_valid, fetch_idx, resolve_valid, resolve_taken, resolve_jump, bht_pred,
    output fetch_ready, pred_valid, pred_taken, flush, bht_rd_en, bht_rd_idx,
           bht_upd_en, bht_upd_idx, bht_upd_taken, mispredict_cnt, resolve_err
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: issues BHT lookups, queues in-flight predictions, retires them and flushes on mispredict.
module branch_pred_ctrl #(
  parameter int LOWER        = 5,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              arst_n,
  branch_pred_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           state;
  logic [FW-1:0]    fcnt;
  logic [LOWER-1:0] q_idx [DEPTH];
  logic             q_pred [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             pend;
  logic [LOWER-1:0] pend_idx;
  logic             flush_r, upd_en, upd_taken, err;
  logic [LOWER-1:0] upd_idx;
  logic [15:0]      mis_cnt;
  logic             run, accept, actual, pop, mis, push;
  always_comb begin
    run    = state == RUN;
    accept = bus.fetch_valid & run & (count + CW'(pend) < CW'(DEPTH));
    actual = bus.resolve_taken | bus.resolve_jump;
    pop    = run & bus.resolve_valid & (count != '0);
    mis    = pop & (actual != q_pred[rd_ptr]);
    push   = pend & ~mis;
  end
  assign bus.fetch_ready    = run & (count + CW'(pend) < CW'(DEPTH));
  assign bus.bht_rd_en      = accept;
  assign bus.bht_rd_idx     = bus.fetch_idx;
  assign bus.pred_valid     = push;
  assign bus.pred_taken     = push & bus.bht_pred;
  assign bus.flush          = flush_r;
  assign bus.bht_upd_en     = upd_en;
  assign bus.bht_upd_idx    = upd_idx;
  assign bus.bht_upd_taken  = upd_taken;
  assign bus.mispredict_cnt = mis_cnt;
  assign bus.resolve_err    = err;
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]  <= pend_idx;
      q_pred[wr_ptr] <= bus.bht_pred;
    end
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= RUN;
      fcnt      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      flush_r   <= 1'b0;
      upd_en    <= 1'b0;
      upd_idx   <= '0;
      upd_taken <= 1'b0;
      mis_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      pend   <= accept & ~mis;
      upd_en <= pop;
      if (accept) pend_idx <= bus.fetch_idx;
      if (pop) begin
        upd_idx   <= q_idx[rd_ptr];
        upd_taken <= actual;
      end
      if (run & bus.resolve_valid & (count == '0)) err <= 1'b1;
      // a mispredict drops the whole wrong path, including a lookup still in flight
      if (mis) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        state   <= FLUSH;
        fcnt    <= FW'(FLUSH_CYCLES);
        flush_r <= 1'b1;
        mis_cnt <= mis_cnt + 16'(~&mis_cnt);
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (!run) begin
          if (fcnt == FW'(1)) begin
            state   <= RUN;
            flush_r <= 1'b0;
          end else fcnt <= fcnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed and random stimulus against a queue-based model of the predictor controller.
module tb_branch_pred_ctrl;
  localparam int LOWER = 5, DEPTH = 4, FC = 2;
  typedef struct {logic [LOWER-1:0] idx; logic pred;} ent_t;
  logic clk = 1'b0, arst_n = 1'b0;
  always #5 clk = ~clk;
  branch_pred_ctrl_if #(.LOWER(LOWER)) bus();
  branch_pred_ctrl #(.LOWER(LOWER), .DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
  ent_t q[$];
  logic [1:0] tbl [32];
  int pend, flush_left, e_cnt, n_chk, n_fail;
  logic [LOWER-1:0] pend_idx, e_upd_idx;
  logic pend_pred, e_upd_en, e_upd_taken, e_err;
  logic run, rdy, acc, pop, act, mis, pv;
  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    pend = 0; flush_left = 0; e_cnt = 0;
    e_upd_en = 0; e_upd_idx = '0; e_upd_taken = 0; e_err = 0;
    pend_idx = '0; pend_pred = 0;
  endtask
  task automatic step(logic fv, logic [LOWER-1:0] fi, logic rv, logic rt, logic rj);
    bus.fetch_valid = fv; bus.fetch_idx = fi;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.resolve_jump = rj;
    #1;
    run = flush_left == 0;
    rdy = run && (q.size() + pend < DEPTH);
    acc = fv && rdy;
    pop = run && rv && q.size() > 0;
    act = rt | rj;
    mis = pop && (act != q[0].pred);
    pv  = pend != 0 && !mis;
    chk("fetch_ready", bus.fetch_ready, rdy);
    chk("bht_rd_en", bus.bht_rd_en, acc);
    if (acc) chk("bht_rd_idx", bus.bht_rd_idx, fi);
    chk("pred_valid", bus.pred_valid, pv);
    chk("pred_taken", bus.pred_taken, pv && pend_pred);
    chk("flush", bus.flush, flush_left > 0);
    chk("bht_upd_en", bus.bht_upd_en, e_upd_en);
    if (e_upd_en) begin
      chk("bht_upd_idx", bus.bht_upd_idx, e_upd_idx);
      chk("bht_upd_taken", bus.bht_upd_taken, e_upd_taken);
    end
    chk("mispredict_cnt", bus.mispredict_cnt, e_cnt);
    chk("resolve_err", bus.resolve_err, e_err);
  endtask
  task automatic adv();
    logic nxt;
    nxt = bus.bht_rd_en ? tbl[bus.bht_rd_idx][1] : bus.bht_pred;
    if (run && bus.resolve_valid && q.size() == 0) e_err = 1;
    e_upd_en = pop;
    if (pop) begin
      e_upd_idx = q[0].idx;
      e_upd_taken = act;
      void'(q.pop_front());
    end
    if (pv) q.push_back('{pend_idx, pend_pred});
    if (mis) begin
      q.delete();
      e_cnt = e_cnt < 65535 ? e_cnt + 1 : e_cnt;
      flush_left = FC;
    end else if (flush_left > 0) flush_left--;
    pend = (acc && !mis) ? 1 : 0;
    if (acc) begin
      pend_idx = bus.fetch_idx;
      pend_pred = tbl[bus.fetch_idx][1];
    end
    // the table itself reacts to the controller's update strobe
    if (bus.bht_upd_en)
      tbl[bus.bht_upd_idx] = bus.bht_upd_taken ? (tbl[bus.bht_upd_idx] == 2'd3 ? 2'd3 : tbl[bus.bht_upd_idx] + 2'd1)
                                               : (tbl[bus.bht_upd_idx] == 2'd0 ? 2'd0 : tbl[bus.bht_upd_idx] - 2'd1);
    @(posedge clk);
    #1;
    bus.bht_pred = nxt;
  endtask
  task automatic idle();
    step(0, '0, 0, 0, 0);
    adv();
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 32; i++) tbl[i] = 2'b01;
    bus.fetch_valid = 0; bus.fetch_idx = '0; bus.resolve_valid = 0;
    bus.resolve_taken = 0; bus.resolve_jump = 0; bus.bht_pred = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush", bus.flush, 0);
    chk("rst_cnt", bus.mispredict_cnt, 0);
    chk("rst_err", bus.resolve_err, 0);
    chk("rst_upd_en", bus.bht_upd_en, 0);
    chk("rst_pred_valid", bus.pred_valid, 0);
    arst_n = 1;
    tbl[3] = 2'd3;
    step(1, 3, 0, 0, 0);
    chk("t1_rd_en", bus.bht_rd_en, 1);
    chk("t1_rd_idx", bus.bht_rd_idx, 3);
    adv();
    step(0, '0, 0, 0, 0);
    chk("t1_pred_valid", bus.pred_valid, 1);
    chk("t1_pred_taken", bus.pred_taken, 1);
    adv();
    step(0, '0, 1, 1, 0); adv();
    idle();
    for (int i = 1; i <= 4; i++) tbl[i] = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      step(1, LOWER'(i), 0, 0, 0);
      adv();
    end
    step(1, 6, 0, 0, 0);
    chk("t2_full_ready", bus.fetch_ready, 0);
    adv();
    step(1, 6, 0, 0, 0); adv();
    step(1, 6, 1, 0, 0);
    chk("t2_pop_ready", bus.fetch_ready, 0);
    adv();
    step(1, 6, 0, 0, 0);
    chk("t2_after_pop_ready", bus.fetch_ready, 1);
    chk("t2_after_pop_rd_en", bus.bht_rd_en, 1);
    adv();
    repeat (4) begin
      step(0, '0, 1, 0, 0);
      adv();
    end
    idle();
    tbl[5] = 2'd3;
    step(1, 5, 0, 0, 0); adv();
    idle();
    step(0, '0, 1, 1, 0); adv();
    step(0, '0, 0, 0, 0);
    chk("t3_upd_en", bus.bht_upd_en, 1);
    chk("t3_upd_idx", bus.bht_upd_idx, 5);
    chk("t3_upd_taken", bus.bht_upd_taken, 1);
    chk("t3_flush", bus.flush, 0);
    chk("t3_cnt", bus.mispredict_cnt, 0);
    adv();
    tbl[7] = 2'd0; tbl[8] = 2'd3;
    step(1, 7, 0, 0, 0); adv();
    step(1, 8, 0, 0, 0); adv();
    idle();
    step(0, '0, 1, 0, 1); adv();
    step(1, 9, 0, 0, 0);
    chk("t4_upd_en", bus.bht_upd_en, 1);
    chk("t4_upd_idx", bus.bht_upd_idx, 7);
    chk("t4_upd_taken", bus.bht_upd_taken, 1);
    chk("t4_flush1", bus.flush, 1);
    chk("t4_ready", bus.fetch_ready, 0);
    chk("t4_cnt", bus.mispredict_cnt, 1);
    adv();
    step(0, '0, 0, 0, 0);
    chk("t4_flush2", bus.flush, 1);
    adv();
    step(0, '0, 0, 0, 0);
    chk("t4_flush_end", bus.flush, 0);
    chk("t4_run_ready", bus.fetch_ready, 1);
    adv();
    tbl[9] = 2'd0;
    step(1, 9, 0, 0, 0); adv();
    idle();
    step(1, 10, 1, 1, 0);
    chk("t5_rd_en", bus.bht_rd_en, 1);
    adv();
    step(0, '0, 0, 0, 0);
    chk("t5_no_pred", bus.pred_valid, 0);
    chk("t5_flush", bus.flush, 1);
    adv();
    idle();
    idle();
    step(0, '0, 1, 0, 0); adv();
    step(0, '0, 0, 0, 0);
    chk("t6_err", bus.resolve_err, 1);
    chk("t6_no_upd", bus.bht_upd_en, 0);
    adv();
    idle();
    step(0, '0, 0, 0, 0);
    chk("t6_err_sticky", bus.resolve_err, 1);
    adv();
    tbl[11] = 2'd0;
    step(1, 11, 0, 0, 0); adv();
    idle();
    step(0, '0, 1, 1, 0); adv();
    chk("t6_mid_flush", bus.flush, 1);
    arst_n = 0;
    #1;
    chk("t6_rst_flush", bus.flush, 0);
    chk("t6_rst_cnt", bus.mispredict_cnt, 0);
    chk("t6_rst_err", bus.resolve_err, 0);
    chk("t6_rst_upd", bus.bht_upd_en, 0);
    model_reset();
    bus.bht_pred = 0;
    @(posedge clk);
    #1;
    arst_n = 1;
    repeat (3000) begin
      step($urandom_range(0, 99) < 60, LOWER'($urandom), $urandom_range(0, 99) < 35,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      adv();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
